// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, default timing and counter sizing for the SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    TURN   = 3'd5
  } state_t;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_ACCESS_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 1;

  function automatic int cnt_width(input int s, input int a, input int h);
    int m;
    m = s;
    if (a > m) m = a;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_arm_local_arbiter_if.sv
// rtl/sram_arm_local_arbiter_if.sv - local master request/ack port of the SRAM arbiter
interface sram_arm_local_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          loc_req;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [DW-1:0] loc_wdata;
  logic          loc_ack;
  logic [DW-1:0] loc_rdata;

  modport master (
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  loc_ack, loc_rdata
  );

  modport slave (
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output loc_ack, loc_rdata
  );
endinterface

// File: rtl/sram_arm_local_arbiter_sync_2ff.sv
// rtl/sram_arm_local_arbiter_sync_2ff.sv - two-flop synchroniser with configurable width and reset value
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sram_arm_local_arbiter.sv
// rtl/sram_arm_local_arbiter.sv - shares an async SRAM between ARM pin passthrough and a timed local master
module sram_arm_local_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW            = 19,
  parameter int DW            = 8,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  wire  [DW-1:0]            ARM_D,
  input  logic [AW-1:0]            ARM_A,
  input  logic                     ARM_CS,
  input  logic                     ARM_OE,
  input  logic                     ARM_WE,
  output logic                     ARM_NWAIT,
  inout  wire  [DW-1:0]            SRAM_D,
  output logic [AW-1:0]            SRAM_A,
  output logic                     SRAM_CS,
  output logic                     SRAM_OE,
  output logic                     SRAM_WE,
  sram_arm_local_arbiter_if.slave  loc
);

  localparam int CW = cnt_width(SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ACCESS_LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          arm_sel;

  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;

  logic          int_cs, int_oe, int_we, int_drv;

  logic          accept, we_eff, timed_nx;
  logic          cs_nx, oe_nx, we_nx, drv_nx, ack_nx, cap;
  logic          local_own;
  logic          sram_d_oe, arm_d_oe;
  logic [DW-1:0] sram_d_out;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~ARM_CS),
    .q     (arm_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_we        <= 1'b0;
      int_cs        <= 1'b1;
      int_oe        <= 1'b1;
      int_we        <= 1'b1;
      int_drv       <= 1'b0;
      loc.loc_ack   <= 1'b0;
      loc.loc_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (timed_nx)
        cnt <= cnt + 1'b1;
      if (accept) begin
        lat_addr  <= loc.loc_addr;
        lat_wdata <= loc.loc_wdata;
        lat_we    <= loc.loc_we;
      end
      int_cs      <= cs_nx;
      int_oe      <= oe_nx;
      int_we      <= we_nx;
      int_drv     <= drv_nx;
      loc.loc_ack <= ack_nx;
      if (cap)
        loc.loc_rdata <= SRAM_D;
    end
  end

  // Strobes are decoded from the next state so they leave the flops clean.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm_sel) state_nx = ARM;
               else if (loc.loc_req) state_nx = SETUP;
      ARM:     if (!arm_sel) state_nx = TURN;
      SETUP:   if (cnt == SETUP_LAST) state_nx = STROBE;
      STROBE:  if (cnt == ACCESS_LAST) state_nx = HOLD;
      HOLD:    if (cnt == HOLD_LAST) state_nx = TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    accept   = (state == IDLE) && (state_nx == SETUP);
    we_eff   = accept ? loc.loc_we : lat_we;
    timed_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    cs_nx    = !timed_nx;
    oe_nx    = !((state_nx == STROBE) && !we_eff);
    we_nx    = !((state_nx == STROBE) && we_eff);
    drv_nx   = timed_nx && we_eff;
    ack_nx   = (state == HOLD) && (state_nx == TURN);
    cap      = (state == STROBE) && (state_nx == HOLD) && !lat_we;
  end

  assign local_own = (state == SETUP) || (state == STROBE) ||
                     (state == HOLD)  || (state == TURN);

  assign SRAM_A  = local_own ? lat_addr : ARM_A;
  assign SRAM_CS = local_own ? int_cs   : ARM_CS;
  assign SRAM_OE = local_own ? int_oe   : ARM_OE;
  assign SRAM_WE = local_own ? int_we   : ARM_WE;

  assign sram_d_oe  = local_own ? int_drv : (!ARM_WE && !ARM_CS);
  assign sram_d_out = local_own ? lat_wdata : ARM_D;
  assign SRAM_D     = sram_d_oe ? sram_d_out : {DW{1'bz}};

  assign arm_d_oe = !local_own && !ARM_OE && !ARM_CS;
  assign ARM_D    = arm_d_oe ? SRAM_D : {DW{1'bz}};

  // Raw pin path so the ARM stalls in the same cycle it selects.
  assign ARM_NWAIT = ARM_CS || !local_own;

endmodule
